data_ram: RTL and testbench

Single-port, byte-wide data memory for the 8-bit CPU.
- Provides data storage for load/store instructions, addressed by the 16-bit CPU address bus.
- Synchronous write and registered (synchronous) read; one clock domain.
- Sits between the CPU datapath (address/store-data/load-data) and nothing else; no bus protocol beyond write_enable.

---
 rtl/data_ram_pkg.sv | 22 ++
 rtl/data_ram_clear_seq.sv | 55 +++++
 rtl/data_ram.sv | 93 +++++++++
 tb/tb_data_ram.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared constants, types and helpers for the byte-wide CPU data memory.
package data_ram_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 65536;

    typedef logic [7:0]  data_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // Index width for the storage array; a single-word memory still needs one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_ram_clear_seq.sv
// Post-reset clear sequencer: walks addresses 0..DEPTH-1, emitting one zero-write per cycle.
module data_ram_clear_seq
    import data_ram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clear_we,
    output logic [IDX_W-1:0] clear_addr,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    clr_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // IDLE is the armed state held during reset; it already clears word 0 on the first edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE, CLR_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = CLR_DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = CLR_CLEAR;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            CLR_DONE: state_d = CLR_DONE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    always_comb begin
        clear_we   = (state_q != CLR_DONE);
        busy       = (state_q != CLR_DONE);
        clear_addr = cnt_q;
    end

endmodule

// File: rtl/data_ram.sv
// Single-port byte-wide data memory, write-first registered read.
// Define DATA_RAM_CLEAR_ON_RESET_EN to zero the whole array after every reset.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy
);

    localparam int                  IDX_W   = idx_width(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  busy_w;
    logic                  clear_we;
    logic [IDX_W-1:0]      clear_addr;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    // Upper address bits only feed the range check; the array is indexed by the low bits.
    assign in_range = ({1'b0, address} < DEPTH_X);
    assign idx      = address[IDX_W-1:0];

`ifdef DATA_RAM_CLEAR_ON_RESET_EN
    data_ram_clear_seq #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .busy       (busy_w)
    );
`else
    assign busy_w     = 1'b0;
    assign clear_we   = 1'b0;
    assign clear_addr = '0;
`endif

    always_comb begin
        wr_en   = write_enable && in_range;
        wr_idx  = idx;
        wr_data = data_in;
        if (busy_w) begin
            wr_en   = clear_we;
            wr_idx  = clear_addr;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Single port: a write always targets the read address, so write-first forwards data_in.
    always_comb begin
        data_out_d = mem[idx];
        if (busy_w || !in_range) begin
            data_out_d = '0;
        end else if (write_enable) begin
            data_out_d = data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_w;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram with a behavioural memory model checked every cycle.
module tb_data_ram;

    localparam int AW = 16;
    localparam int DW = 8;
`ifdef DATA_RAM_CLEAR_ON_RESET_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1024;
`endif

    logic          clk;
    logic          rst;
    logic          write_enable;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          busy;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    data_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_enable = we;
        address      = a;
        data_in      = d;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a plain array plus "known" flags; unwritten words have no defined value.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    logic [DW-1:0] exp_dout;
    bit            exp_valid = 0;
`ifdef DATA_RAM_CLEAR_ON_RESET_EN
    int            clr_left = 0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_dout  <= '0;
            exp_valid <= 1'b1;
`ifdef DATA_RAM_CLEAR_ON_RESET_EN
            clr_left  <= DEPTH;
`endif
        end else begin
`ifdef DATA_RAM_CLEAR_ON_RESET_EN
            if (clr_left != 0) begin
                clr_left  <= clr_left - 1;
                exp_dout  <= '0;
                exp_valid <= 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i]   <= '0;
                    m_known[i] <= 1'b1;
                end
            end else
`endif
            if (int'(address) >= DEPTH) begin
                exp_dout  <= '0;
                exp_valid <= 1'b1;
            end else if (write_enable) begin
                m_mem[int'(address)]   <= data_in;
                m_known[int'(address)] <= 1'b1;
                exp_dout  <= data_in;
                exp_valid <= 1'b1;
            end else begin
                exp_dout  <= m_mem[int'(address)];
                exp_valid <= m_known[int'(address)];
            end
        end
    end

    logic busy_exp;
`ifdef DATA_RAM_CLEAR_ON_RESET_EN
    assign busy_exp = rst || (clr_left != 0);
`else
    assign busy_exp = 1'b0;
`endif

    always @(negedge clk) begin
        if (started) begin
            if (rst) check("dout_during_rst", {24'd0, data_out}, 32'd0);
            else if (exp_valid) check("dout_model", {24'd0, data_out}, {24'd0, exp_dout});
            check("busy_model", {31'd0, busy}, {31'd0, busy_exp});
        end
    end

    initial begin
        int n;
        rst = 1'b0; write_enable = 1'b0; address = '0; data_in = '0;
        #2 rst = 1'b1;
        #1 started = 1;
        check("reset_dout", {24'd0, data_out}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

`ifdef DATA_RAM_CLEAR_ON_RESET_EN
        n = 0;
        while (busy && n < 200) begin cyc(1'b0, 16'd0, 8'd0); n++; end
        check("init_clear_len", n, DEPTH);
        cyc(1'b1, 16'd5, 8'h33);
        cyc(1'b0, 16'd5, 8'h00); check("preload_5", {24'd0, data_out}, 32'h33);
        #3 rst = 1'b1;
        #1 check("async_rst_dout", {24'd0, data_out}, 32'd0);
        check("busy_in_rst", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            cyc((n == 3), 16'd6, 8'h99);
            n++;
        end
        check("clear_len", n, 16);
        cyc(1'b0, 16'd5, 8'h00); check("cleared_5", {24'd0, data_out}, 32'h00);
        cyc(1'b0, 16'd6, 8'h00); check("dropped_wr_6", {24'd0, data_out}, 32'h00);
        cyc(1'b1, 16'd6, 8'h44);
        cyc(1'b0, 16'd6, 8'h00); check("post_clear_wr", {24'd0, data_out}, 32'h44);
`else
        cyc(1'b1, 16'd0, 8'hFF); check("wr0_fwd", {24'd0, data_out}, 32'hFF);
        cyc(1'b1, 16'd2, 8'hAA);
        cyc(1'b1, 16'd3, 8'hF0);
        cyc(1'b0, 16'd0, 8'h00); check("rd0", {24'd0, data_out}, 32'hFF);
        cyc(1'b0, 16'd2, 8'h00); check("rd2", {24'd0, data_out}, 32'hAA);
        cyc(1'b0, 16'd3, 8'h00); check("rd3", {24'd0, data_out}, 32'hF0);

        cyc(1'b0, 16'd2, 8'h00); check("pre_rst", {24'd0, data_out}, 32'hAA);
        #3 rst = 1'b1;
        #1 check("async_rst", {24'd0, data_out}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold", {24'd0, data_out}, 32'd0);
        rst = 1'b0;
        cyc(1'b0, 16'd2, 8'h00); check("mem_kept", {24'd0, data_out}, 32'hAA);

        cyc(1'b1, 16'd7, 8'h5C); check("rdw_fwd", {24'd0, data_out}, 32'h5C);
        cyc(1'b0, 16'd7, 8'h00); check("rdw_stored", {24'd0, data_out}, 32'h5C);

        cyc(1'b0, 16'd2, 8'h11); check("we_low", {24'd0, data_out}, 32'hAA);
        cyc(1'b0, 16'd3, 8'h00);
        cyc(1'b0, 16'd2, 8'h00); check("we_low_kept", {24'd0, data_out}, 32'hAA);

        cyc(1'b1, 16'h0400, 8'h77); check("oor_wr_rd", {24'd0, data_out}, 32'h00);
        cyc(1'b0, 16'h0400, 8'h00); check("oor_rd", {24'd0, data_out}, 32'h00);
        cyc(1'b0, 16'h0000, 8'h00); check("oor_alias0", {24'd0, data_out}, 32'hFF);
        cyc(1'b1, 16'h03FF, 8'h42);
        cyc(1'b1, 16'hFFFF, 8'h12); check("oor_top", {24'd0, data_out}, 32'h00);
        cyc(1'b0, 16'h03FF, 8'h00); check("last_word", {24'd0, data_out}, 32'h42);

        for (int i = 0; i < 16; i++) cyc(1'b1, AW'(i * 37 + 9), DW'(i * 13 + 8'h5A));
        for (int i = 0; i < 16; i++) cyc(1'b0, AW'(i * 37 + 9), 8'h00);
        cyc(1'b0, 16'd46, 8'h00); check("sweep_46", {24'd0, data_out}, 32'h67);
`endif
        cyc(1'b0, 16'd0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
